// File: rtl/speed_display_if.sv
// Bundles the speed-result input and the display/status outputs of speed_display.
// master drives speed/done and observes the outputs; slave is the display block.
// Combinational wiring only, no storage.
interface speed_display_if #(
  parameter int WIDTH_SPEED = 14
);
  logic [WIDTH_SPEED-1:0] speed;
  logic                   done;
  logic [15:0]            bcd;
  logic                   valid;
  logic                   busy;
  logic                   overspeed;
  logic                   sat;
  logic [6:0]             seg;
  logic [3:0]             an;

  modport master (
    output speed, done,
    input  bcd, valid, busy, overspeed, sat, seg, an
  );

  modport slave (
    input  speed, done,
    output bcd, valid, busy, overspeed, sat, seg, an
  );
endinterface

// File: rtl/speed_display.sv
// Captures a speed result on done's rising edge, converts it to BCD by double-dabble, scans a 4-digit display.
// Latency: new bcd/flags visible 15 clocks after the capture edge; seg/an change one edge after bcd/index change.
// No backpressure: a done edge arriving while a conversion is running is dropped, not queued.
module speed_display #(
  parameter int WIDTH_SPEED = 14,
  parameter int SYS_FREQ    = 50000000,
  parameter int FRAME_HZ    = 250,
  parameter int SPEED_LIMIT = 60
) (
  input  logic            clk,
  input  logic            reset,
  speed_display_if.slave  bus
);

  localparam int DIG_TICKS = SYS_FREQ / (4 * FRAME_HZ);
  localparam int TW        = (DIG_TICKS > 1) ? $clog2(DIG_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIG_TICKS - 1);
  localparam logic [4:0]    ITER_LAST = 5'(WIDTH_SPEED - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_SPEED-1:0] shreg_q, shreg_d;
  logic [15:0]            scr_q, scr_d, adj;
  logic [4:0]             cnt_q, cnt_d;
  logic                   sat_n_q, sat_n_d, ovs_n_q, ovs_n_d;
  logic [15:0]            bcd_q, bcd_d;
  logic                   valid_q, valid_d, busy_q, busy_d;
  logic                   ovs_q, ovs_d, sat_q, sat_d;
  logic                   done_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [1:0]             idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic [3:0]             digit;
  logic                   blank;
  logic [31:0]            speed_ext;
  logic                   start;

  assign speed_ext = 32'(bus.speed);
  assign start     = bus.done & ~done_q;

  // Active-low {g..a} pattern for one decimal digit.
  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 7'b1000000;
      4'd1:    enc7 = 7'b1111001;
      4'd2:    enc7 = 7'b0100100;
      4'd3:    enc7 = 7'b0110000;
      4'd4:    enc7 = 7'b0011001;
      4'd5:    enc7 = 7'b0010010;
      4'd6:    enc7 = 7'b0000010;
      4'd7:    enc7 = 7'b1111000;
      4'd8:    enc7 = 7'b0000000;
      4'd9:    enc7 = 7'b0010000;
      default: enc7 = 7'b1111111;
    endcase
  endfunction

  // Conversion FSM: capture, one double-dabble iteration per clock, then publish.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    sat_n_d = sat_n_q;
    ovs_n_d = ovs_n_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    ovs_d   = ovs_q;
    sat_d   = sat_q;
    adj     = scr_q;
    for (int k = 0; k < 4; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          // Clamp before converting so the 4 BCD digits cannot overflow.
          shreg_d = (speed_ext > 32'd9999) ? WIDTH_SPEED'(9999) : bus.speed;
          scr_d   = '0;
          sat_n_d = (speed_ext > 32'd9999);
          ovs_n_d = (speed_ext > 32'(SPEED_LIMIT));
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, shreg_d} = {adj[14:0], shreg_q, 1'b0};
        if (cnt_q == ITER_LAST) state_d = UPDATE;
        else                    cnt_d   = cnt_q + 5'd1;
      end
      UPDATE: begin
        bcd_d   = scr_q;
        ovs_d   = ovs_n_q;
        sat_d   = sat_n_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan: free-running digit timer; seg built from next-state values so it moves with an.
  always_comb begin
    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
    idx_d  = (tick_q == TICK_LAST) ? idx_q + 2'd1 : idx_q;
    digit  = bcd_d[4*idx_d +: 4];
    blank  = 1'b0;
    case (idx_d)
      2'd1:    blank = (bcd_d[15:4]  == 12'd0);
      2'd2:    blank = (bcd_d[15:8]  == 8'd0);
      2'd3:    blank = (bcd_d[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    seg_d = blank ? 7'b1111111 : enc7(digit);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sat_n_q <= 1'b0;
      ovs_n_q <= 1'b0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovs_q   <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      sat_n_q <= sat_n_d;
      ovs_n_q <= ovs_n_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovs_q   <= ovs_d;
      sat_q   <= sat_d;
      done_q  <= bus.done;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.overspeed = ovs_q;
  assign bus.sat       = sat_q;
  assign bus.seg       = seg_q;
  assign bus.an        = ~(4'b0001 << idx_q);

endmodule

// File: tb/tb_speed_display.sv
// Bench for speed_display: directed stimulus, scoreboard of expected results, monitor on busy falling.
// Display scan runs with two clocks per digit.
module tb_speed_display;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovs;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  int   rise_cnt = 0;
  int   busy_len = 0;
  logic busy_prev = 1'b0;
  exp_t exp_q[$];

  speed_display_if #(.WIDTH_SPEED(14)) bus ();

  speed_display #(
    .WIDTH_SPEED(14),
    .SYS_FREQ   (8),
    .FRAME_HZ   (1),
    .SPEED_LIMIT(60)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pulse(input int s);
    bus.speed = 14'(s);
    bus.done  = 1'b1;
    @(negedge clk);
    bus.done  = 1'b0;
  endtask

  task automatic push(input logic [15:0] b, input logic o, input logic s);
    exp_t e;
    e.bcd = b;
    e.ovs = o;
    e.sat = s;
    exp_q.push_back(e);
  endtask

  // Walk one full scan frame and compare seg against the expected pattern for whichever digit is enabled.
  task automatic check_disp(input logic [6:0] d0, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [6:0] d3);
    logic [6:0] e;
    for (int i = 0; i < 8; i++) begin
      case (bus.an)
        4'b1110: e = d0;
        4'b1101: e = d1;
        4'b1011: e = d2;
        4'b0111: e = d3;
        default: e = 7'bxxxxxxx;
      endcase
      chk($sformatf("seg an=%b", bus.an), {25'd0, bus.seg}, {25'd0, e});
      @(negedge clk);
    end
  endtask

  // Monitor: every completed conversion (busy falls with valid high) is checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy && !busy_prev) rise_cnt++;
    if (bus.busy) busy_len++;
    if (busy_prev && !bus.busy && bus.valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(bus.bcd), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("bcd", 32'(bus.bcd), 32'(e.bcd));
        chk("overspeed", 32'(bus.overspeed), 32'(e.ovs));
        chk("sat", 32'(bus.sat), 32'(e.sat));
        chk("busy_clocks", busy_len, 15);
      end
    end
    if (!bus.busy) busy_len = 0;
    busy_prev = bus.busy;
  end

  initial begin
    logic [3:0] ea;
    int r0;
    reset     = 1'b1;
    bus.done  = 1'b0;
    bus.speed = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_bcd", 32'(bus.bcd), 0);
    chk("rst_valid", 32'(bus.valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ovs", 32'(bus.overspeed), 0);
    chk("rst_sat", 32'(bus.sat), 0);
    reset = 1'b0;
    // Scan order after reset: two clocks per digit, units first, digits 1-3 blanked.
    for (int i = 0; i < 10; i++) begin
      ea = ~(4'b0001 << ((i / 2) % 4));
      chk($sformatf("scan_an[%0d]", i), 32'(bus.an), 32'(ea));
      chk($sformatf("scan_seg[%0d]", i), 32'(bus.seg),
          (ea == 4'b1110) ? 32'b1000000 : 32'b1111111);
      @(negedge clk);
    end

    push(16'h1234, 1'b1, 1'b0);
    pulse(1234);
    repeat (16) @(negedge clk);
    chk("valid_after_1234", 32'(bus.valid), 1);
    check_disp(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    push(16'h0072, 1'b1, 1'b0);
    pulse(72);
    repeat (16) @(negedge clk);
    check_disp(7'b0100100, 7'b1111000, 7'b1111111, 7'b1111111);

    push(16'h9999, 1'b1, 1'b1);
    pulse(14400);
    repeat (16) @(negedge clk);
    check_disp(7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

    push(16'h0045, 1'b0, 1'b0);
    pulse(45);
    repeat (16) @(negedge clk);

    // done held high: one conversion only, no retrigger on return to idle.
    r0 = rise_cnt;
    push(16'h0500, 1'b1, 1'b0);
    bus.speed = 14'd500;
    bus.done  = 1'b1;
    repeat (40) @(negedge clk);
    bus.done = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_done_rises", rise_cnt - r0, 1);

    // A second edge at E5 is dropped.
    r0 = rise_cnt;
    push(16'h0500, 1'b1, 1'b0);
    pulse(500);
    repeat (4) @(negedge clk);
    pulse(900);
    repeat (16) @(negedge clk);
    chk("ignored_bcd", 32'(bus.bcd), 32'h0500);
    chk("ignored_rises", rise_cnt - r0, 1);

    // Reset at E7 aborts the conversion.
    pulse(321);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_bcd", 32'(bus.bcd), 0);
    chk("abort_valid", 32'(bus.valid), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    push(16'h0321, 1'b1, 1'b0);
    pulse(321);
    repeat (16) @(negedge clk);
    chk("final_bcd", 32'(bus.bcd), 32'h0321);

    chk("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
